// File: rtl/pb_event_scheduler.sv
// pb_event_scheduler
// Turns N debounced button levels into discrete press events. A held button
// auto-repeats. All buttons share one event channel, picked round-robin.
// Events go to the consumer over valid/ready. A one-cycle evt_ovf pulse marks
// an event dropped because that button already had one waiting.
module pb_event_scheduler #(
   parameter int unsigned N_BTN    = 4,
   parameter int unsigned ID_W     = 2,
   parameter int unsigned CNT_W    = 24,
   parameter int unsigned HOLD_CYC = 10_000_000,
   parameter int unsigned REP_CYC  = 5_000_000
) (
   input  logic             clk_100,
   input  logic             rst,
   input  logic [N_BTN-1:0] pb_level,
   input  logic             rep_en,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [ID_W-1:0]  evt_id,
   output logic             evt_repeat,
   output logic             evt_ovf
);

   // Repeat FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_REPT = 2'd2;

   // Terminal counts. A period of 2**CNT_W wraps to all-ones, which is the
   // last count before the counter would wrap.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

   // Edge detect
   logic [N_BTN-1:0] prev_q;
   logic [N_BTN-1:0] rise;

   // Repeat FSM
   logic [1:0]       state_q, state_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_BTN-1:0] owner_oh;
   logic             owner_lvl;
   logic [ID_W-1:0]  low_idx;
   logic             tick;

   // Pending events, one slot per button
   logic [N_BTN-1:0] pend_q, pend_d;
   logic [N_BTN-1:0] pend_rep_q, pend_rep_d;
   logic [N_BTN-1:0] set_vec;
   logic [N_BTN-1:0] set_rep;
   logic [N_BTN-1:0] clr_vec;
   logic [N_BTN-1:0] drop_vec;

   // Arbiter and output register
   logic [ID_W-1:0]  rr_last_q, rr_last_d;
   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;
   logic             pick_rep;
   logic [N_BTN-1:0] pick_oh;
   logic             load;
   logic             valid_q, valid_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic             rep_q, rep_d;
   logic             ovf_q, ovf_d;

   assign rise      = pb_level & ~prev_q;
   assign owner_lvl = |(pb_level & owner_oh);
   assign load      = ~valid_q | evt_ready;

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_btn
         assign owner_oh[gi] = (owner_q == ID_W'(gi));
         assign pick_oh[gi]  = pick_found & (pick_idx == ID_W'(gi));
         // A repeat tick can only hit the owner, which is already held, so a
         // rise on the same button never coincides with its tick.
         assign set_vec[gi]  = rise[gi] | (tick & owner_oh[gi]);
         assign set_rep[gi]  = ~rise[gi];
         assign clr_vec[gi]  = load & pick_oh[gi];
         // Slot still occupied after this cycle's clear: the new event is lost.
         assign drop_vec[gi] = set_vec[gi] & pend_q[gi] & ~clr_vec[gi];
         // Set wins over clear, so an event arriving as the old one leaves is kept.
         assign pend_d[gi]   = set_vec[gi] | (pend_q[gi] & ~clr_vec[gi]);
         assign pend_rep_d[gi] = (set_vec[gi] & ~(pend_q[gi] & ~clr_vec[gi]))
                                 ? set_rep[gi]
                                 : (pend_rep_q[gi] & ~clr_vec[gi]);
      end
   endgenerate

   // Lowest-index rising button becomes the new repeat owner
   always_comb begin
      low_idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (rise[i]) begin
            low_idx = ID_W'(i);
         end
      end
   end

   // Repeat FSM: time how long the owner is held and emit repeat ticks
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      tick    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|rise) begin
               owner_d = low_idx;
               cnt_d   = '0;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!owner_lvl) begin
               state_d = ST_IDLE;
            end else if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               tick    = rep_en;
               state_d = ST_REPT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_REPT: begin
            if (!owner_lvl) begin
               state_d = ST_IDLE;
            end else if (cnt_q == REP_LAST) begin
               cnt_d = '0;
               tick  = rep_en;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Round-robin pick: first pending slot after rr_last, with wrap. Larger
   // offsets are visited first so the nearest candidate overwrites them.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_rep   = 1'b0;
      for (int off = N_BTN; off >= 1; off--) begin
         for (int j = 0; j < N_BTN; j++) begin
            if (pend_q[j] && (((int'(rr_last_q) + off) % int'(N_BTN)) == j)) begin
               pick_found = 1'b1;
               pick_idx   = ID_W'(j);
               pick_rep   = pend_rep_q[j];
            end
         end
      end
   end

   // Output register next state: reload whenever empty or being accepted
   always_comb begin
      valid_d   = valid_q;
      id_d      = id_q;
      rep_d     = rep_q;
      rr_last_d = rr_last_q;
      ovf_d     = |drop_vec;
      if (load) begin
         valid_d = pick_found;
         if (pick_found) begin
            id_d      = pick_idx;
            rep_d     = pick_rep;
            rr_last_d = pick_idx;
         end
      end
   end

   // State registers. prev tracks the pins even in reset so a button held
   // through reset is not mistaken for a new press afterwards.
   always_ff @(posedge clk_100) begin
      prev_q <= pb_level;
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         cnt_q      <= '0;
         pend_q     <= '0;
         pend_rep_q <= '0;
         rr_last_q  <= ID_W'(N_BTN - 1);
         valid_q    <= 1'b0;
         id_q       <= '0;
         rep_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pend_rep_q <= pend_rep_d;
         rr_last_q  <= rr_last_d;
         valid_q    <= valid_d;
         id_q       <= id_d;
         rep_q      <= rep_d;
         ovf_q      <= ovf_d;
      end
   end

   assign evt_valid  = valid_q;
   assign evt_id     = id_q;
   assign evt_repeat = rep_q;
   assign evt_ovf    = ovf_q;

endmodule
